row_scan_decoder: RTL and testbench



---
 rtl/row_scan_decoder_pkg.sv | 25 ++
 rtl/row_scan_decoder_if.sv | 30 +++
 rtl/row_scan_decoder_onehot_decode.sv | 22 ++
 rtl/row_scan_decoder.sv | 137 +++++++++++++
 tb/tb_row_scan_decoder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/row_scan_decoder_pkg.sv
// Shared definitions for the row scan decoder.
//   scan_state_t : scan FSM state encoding (IDLE, BLANK, DRIVE)
//   cnt_width    : width of the shared dwell/blank down-counter
//   idx_in_range : true when a row index addresses an existing row
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // One counter times both phases, so it must hold the larger of the two
    // durations.
    function automatic int cnt_width(input int dwell, input int blank_c);
        int m;
        m = (dwell > blank_c) ? dwell : blank_c;
        return $clog2(m + 1);
    endfunction

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/row_scan_decoder_if.sv
// Controller <-> row scan decoder bundle.
//   en          : scan enable (controller -> decoder)
//   load        : single-cycle jump request (controller -> decoder)
//   load_idx    : jump target row (controller -> decoder)
//   row_oh      : registered one-hot row select (decoder -> drivers)
//   row_idx     : current row index (decoder -> controller)
//   blank       : no row driven (decoder -> controller)
//   frame_start : first driven cycle of row 0 (decoder -> controller)
interface row_scan_decoder_if #(
    parameter int N_ROWS = 8,
    parameter int IDX_W  = $clog2(N_ROWS)
) ();
    logic              en;
    logic              load;
    logic [IDX_W-1:0]  load_idx;
    logic [N_ROWS-1:0] row_oh;
    logic [IDX_W-1:0]  row_idx;
    logic              blank;
    logic              frame_start;

    modport master (
        output en, load, load_idx,
        input  row_oh, row_idx, blank, frame_start
    );

    modport slave (
        input  en, load, load_idx,
        output row_oh, row_idx, blank, frame_start
    );
endinterface

// File: rtl/row_scan_decoder_onehot_decode.sv
// Combinational row index to one-hot decoder.
//   idx : row index
//   oh  : one-hot select; out-of-range indices select bit 0, as the
//         legacy 3-to-8 decoder's default branch did
module onehot_decode
    import scan_pkg::*;
#(
    parameter int N_ROWS = 8,
    parameter int IDX_W  = $clog2(N_ROWS)
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [N_ROWS-1:0] oh
);
    always_comb begin
        oh = '0;
        if (idx_in_range(32'(idx), N_ROWS)) begin
            oh[idx] = 1'b1;
        end else begin
            oh[0] = 1'b1;
        end
    end
endmodule

// File: rtl/row_scan_decoder.sv
// LED matrix row scanner: walks the row index on a dwell schedule with
// optional blanking gaps and drives a registered one-hot row select.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of row_scan_decoder_if
//              (en, load, load_idx in; row_oh, row_idx, blank, frame_start out)
module row_scan_decoder
    import scan_pkg::*;
#(
    parameter int N_ROWS     = 8,
    parameter int IDX_W      = $clog2(N_ROWS),
    parameter int DWELL_CYC  = 1000,
    parameter int BLANK_CYC  = 2,
    parameter int ACTIVE_LOW = 0
) (
    input  logic          clk,
    input  logic          rst,
    row_scan_decoder_if.slave bus
);
    localparam int                CNT_W     = cnt_width(DWELL_CYC, BLANK_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DWELL_LD  = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0]  BLANK_LD  = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ROWS - 1);
    localparam logic [N_ROWS-1:0] POL_MASK  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam bit                HAS_BLANK = (BLANK_CYC > 0);

    // Every new row (and every (re)start) begins with a blanking gap when one
    // is configured, otherwise it goes straight to driving.
    localparam scan_state_t      ENTRY_ST = HAS_BLANK ? BLANK : DRIVE;
    localparam logic [CNT_W-1:0] ENTRY_LD = HAS_BLANK ? BLANK_LD : DWELL_LD;

    scan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  row_idx_q, row_idx_d;
    logic [N_ROWS-1:0] row_oh_q, row_oh_d;
    logic              blank_q, blank_d;
    logic              frame_start_q, frame_start_d;

    logic [IDX_W-1:0]  load_tgt;
    logic [N_ROWS-1:0] dec_oh;
    logic              restart;
    logic              drive_d;

    // Decode the next index so the registered select lines up with the
    // registered state.
    onehot_decode #(
        .N_ROWS (N_ROWS),
        .IDX_W  (IDX_W)
    ) u_dec (
        .idx (row_idx_d),
        .oh  (dec_oh)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_idx_d     = row_idx_q;
        restart       = 1'b0;
        load_tgt      = idx_in_range(32'(bus.load_idx), N_ROWS) ? bus.load_idx : '0;

        if (!bus.en) begin
            // Disable overrides everything; a load still moves the retained row.
            state_d = IDLE;
            cnt_d   = '0;
            if (bus.load) begin
                row_idx_d = load_tgt;
            end
        end else if (bus.load) begin
            // Load beats a coincident dwell-end increment.
            row_idx_d = load_tgt;
            state_d   = ENTRY_ST;
            cnt_d     = ENTRY_LD;
            restart   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ENTRY_ST;
                    cnt_d   = ENTRY_LD;
                end
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = DRIVE;
                        cnt_d   = DWELL_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        row_idx_d = (row_idx_q == LAST_IDX) ? '0 : row_idx_q + IDX_ONE;
                        state_d   = ENTRY_ST;
                        cnt_d     = ENTRY_LD;
                        restart   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        drive_d       = (state_d == DRIVE);
        row_oh_d      = (drive_d ? dec_oh : '0) ^ POL_MASK;
        blank_d       = !drive_d;
        // A DRIVE period starts either on entry from another state or when a
        // gapless schedule restarts DRIVE in place (row advance or load).
        frame_start_d = drive_d && ((state_q != DRIVE) || restart) && (row_idx_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            row_idx_q     <= '0;
            row_oh_q      <= POL_MASK;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_idx_q     <= row_idx_d;
            row_oh_q      <= row_oh_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.row_oh      = row_oh_q;
    assign bus.row_idx     = row_idx_q;
    assign bus.blank       = blank_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_row_scan_decoder.sv
// Scoreboard bench for row_scan_decoder: two instances (blanked active-high,
// gapless active-low) share one stimulus stream; a row-period timeline model
// predicts every output cycle.
module tb_row_scan_decoder;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int DW = 4;
    localparam int BLANK_OF [2] = '{1, 0};
    localparam int AL_OF    [2] = '{0, 1};

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       blank;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    row_scan_decoder_if #(.N_ROWS(N), .IDX_W(IW)) bus_a ();
    row_scan_decoder_if #(.N_ROWS(N), .IDX_W(IW)) bus_b ();

    row_scan_decoder #(
        .N_ROWS(N), .IDX_W(IW), .DWELL_CYC(DW), .BLANK_CYC(1), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    row_scan_decoder #(
        .N_ROWS(N), .IDX_W(IW), .DWELL_CYC(DW), .BLANK_CYC(0), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: a scanning instance sits at offset pos within its row period
    // (B blank cycles then DW driven cycles); rows advance when pos wraps.
    int m_on  [2] = '{0, 0};
    int m_row [2] = '{0, 0};
    int m_pos [2] = '{0, 0};

    task automatic model_step(input int i, input bit r, input bit e, input bit l,
                              input int li, output exp_t ex);
        int b, p, tgt;
        bit drive;
        b   = BLANK_OF[i];
        p   = DW + b;
        tgt = (li < N) ? li : 0;
        if (r) begin
            m_on[i] = 0; m_row[i] = 0; m_pos[i] = 0;
        end else if (!e) begin
            m_on[i] = 0;
            if (l) m_row[i] = tgt;
        end else if (l) begin
            m_row[i] = tgt; m_on[i] = 1; m_pos[i] = 0;
        end else if (m_on[i] == 0) begin
            m_on[i] = 1; m_pos[i] = 0;
        end else begin
            m_pos[i] = m_pos[i] + 1;
            if (m_pos[i] == p) begin
                m_pos[i] = 0;
                m_row[i] = (m_row[i] + 1) % N;
            end
        end
        drive    = (m_on[i] != 0) && (m_pos[i] >= b);
        ex.oh    = drive ? 8'(1 << m_row[i]) : 8'h00;
        if (AL_OF[i] != 0) ex.oh = ~ex.oh;
        ex.idx   = 3'(m_row[i]);
        ex.blank = !drive;
        ex.fs    = drive && (m_pos[i] == b) && (m_row[i] == 0);
    endtask

    task automatic cyc(input bit r, input bit e, input bit l, input int li);
        exp_t ea, eb;
        @(posedge clk);
        #2;
        rst            = r;
        bus_a.en       = e;
        bus_a.load     = l;
        bus_a.load_idx = 3'(li);
        bus_b.en       = e;
        bus_b.load     = l;
        bus_b.load_idx = 3'(li);
        model_step(0, r, e, l, li, ea);
        qa.push_back(ea);
        model_step(1, r, e, l, li, eb);
        qb.push_back(eb);
    endtask

    // Scan with en=1 until dut_a's model is about to sit at (row, pos) in the
    // coming cycle, so the next issued input lands on that cycle.
    task automatic run_until(input int row, input int pos);
        int n;
        n = 0;
        while (!(m_on[0] != 0 && m_row[0] == row && m_pos[0] == pos) && n < 100) begin
            cyc(1'b0, 1'b1, 1'b0, 0);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL run_until row=%0d pos=%0d not reached within %0d cycles", row, pos, n);
        end
    endtask

    task automatic check(input string nm, input int inst, input logic [7:0] act,
                         input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, inst, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare 1 time unit after
    // the edge, one cycle after the matching stimulus was pushed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("row_oh",      0, bus_a.row_oh,              e.oh);
                check("row_idx",     0, 8'(bus_a.row_idx),         8'(e.idx));
                check("blank",       0, 8'(bus_a.blank),           8'(e.blank));
                check("frame_start", 0, 8'(bus_a.frame_start),     8'(e.fs));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("row_oh",      1, bus_b.row_oh,              e.oh);
                check("row_idx",     1, 8'(bus_b.row_idx),         8'(e.idx));
                check("blank",       1, 8'(bus_b.blank),           8'(e.blank));
                check("frame_start", 1, 8'(bus_b.frame_start),     8'(e.fs));
            end
        end
    end

    initial begin
        bus_a.en = 1'b0; bus_a.load = 1'b0; bus_a.load_idx = '0;
        bus_b.en = 1'b0; bus_b.load = 1'b0; bus_b.load_idx = '0;

        // Reset, then a full frame plus the wrap back to row 0.
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0);
        repeat (45) cyc(1'b0, 1'b1, 1'b0, 0);

        // Load mid-DRIVE of row 2, then load coincident with row 2's dwell end.
        run_until(2, 2);
        cyc(1'b0, 1'b1, 1'b1, 5);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 0);
        run_until(2, 4);
        cyc(1'b0, 1'b1, 1'b1, 5);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 0);

        // Drop en during row 3, then resume at the retained row.
        run_until(3, 2);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 0);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 0);

        // Reset in the middle of a driven row.
        run_until(4, 2);
        cyc(1'b1, 1'b1, 1'b0, 0);
        repeat (6) cyc(1'b0, 1'b1, 1'b0, 0);

        // Load while disabled only moves the row; resume then wraps 7 -> 0.
        cyc(1'b0, 1'b0, 1'b1, 7);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 0);
        repeat (12) cyc(1'b0, 1'b1, 1'b0, 0);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 19) == 0),
                int'($urandom_range(0, N - 1)));
        end

        @(posedge clk);
        #3;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain pending_a=%0d pending_b=%0d required=0", qa.size(), qb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
